// File: rtl/cache_pkg.sv
// Shared state encoding, default geometry and sizing helper for the
// cache_refill block.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESP,
    FLUSH
  } cache_state_e;

  localparam int unsigned DefNumSets       = 16;
  localparam int unsigned DefAssociativity = 2;
  localparam int unsigned DefTagWidth      = 8;
  localparam int unsigned DefDataWidth     = 32;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int unsigned clog2_min2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Per-set round-robin victim way pointers: bulk clear, advance of one set,
// and combinational read of one set's current victim.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int unsigned NumSets       = DefNumSets,
  parameter int unsigned Associativity = DefAssociativity,
  localparam int unsigned SetWidth     = clog2_min2(NumSets),
  localparam int unsigned WayWidth     = clog2_min2(Associativity)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                adv_i,
  input  logic [SetWidth-1:0] adv_set_i,
  input  logic [SetWidth-1:0] rd_set_i,
  output logic [WayWidth-1:0] rd_way_o
);

  localparam logic [SetWidth-1:0] SetMask = SetWidth'(NumSets - 1);
  localparam logic [WayWidth-1:0] LastWay = WayWidth'(Associativity - 1);

  logic [WayWidth-1:0] ptr_q [NumSets];
  logic [WayWidth-1:0] adv_cur;
  logic [WayWidth-1:0] adv_nxt;

  assign rd_way_o = ptr_q[rd_set_i & SetMask];
  assign adv_cur  = ptr_q[adv_set_i & SetMask];
  // Explicit wrap keeps the pointer at 0 for a direct-mapped configuration.
  assign adv_nxt  = (adv_cur == LastWay) ? '0 : adv_cur + WayWidth'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int unsigned s = 0; s < NumSets; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (adv_i) begin
      ptr_q[adv_set_i & SetMask] <= adv_nxt;
    end
  end

endmodule

// File: rtl/cache_refill.sv
// Set-associative blocking read cache: serves hits, refills misses from
// memory into a round-robin victim way, and supports a walked flush.
module cache_refill
  import cache_pkg::*;
#(
  parameter int unsigned NumSets       = DefNumSets,
  parameter int unsigned Associativity = DefAssociativity,
  parameter int unsigned TagWidth      = DefTagWidth,
  parameter int unsigned DataWidth     = DefDataWidth,
  localparam int unsigned SetWidth     = clog2_min2(NumSets),
  localparam int unsigned WayWidth     = clog2_min2(Associativity)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [SetWidth-1:0]  req_set_i,
  input  logic [TagWidth-1:0]  req_tag_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [DataWidth-1:0] resp_data_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [SetWidth-1:0]  mem_req_set_o,
  output logic [TagWidth-1:0]  mem_req_tag_o,
  input  logic                 mem_resp_valid_i,
  input  logic [DataWidth-1:0] mem_resp_data_i,
  input  logic                 flush_i,
  output logic                 flush_busy_o
);

  localparam int unsigned CntWidth  = SetWidth + 1;
  localparam int unsigned AddrWidth = SetWidth + ((Associativity > 1) ? WayWidth : 0);
  localparam int unsigned DataDepth = 1 << AddrWidth;
  localparam logic [SetWidth-1:0] SetMask  = SetWidth'(NumSets - 1);
  localparam logic [CntWidth-1:0] LastSet  = CntWidth'(NumSets - 1);

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  cache_state_e        state_q, state_d;
  logic [SetWidth-1:0] set_q;
  logic [TagWidth-1:0] tag_q;
  logic                resp_hit_q;
  logic [DataWidth-1:0] resp_data_q;
  logic [CntWidth-1:0] flush_cnt_q;
  block_info_t         info_q [NumSets][Associativity];
  logic [DataWidth-1:0] data_q [DataDepth];

  logic                accept;
  logic                fill;
  logic                hit;
  logic [WayWidth-1:0] hit_way;
  logic [WayWidth-1:0] vict_way;
  logic [SetWidth-1:0] flush_set;
  logic [AddrWidth-1:0] rd_addr;
  logic [AddrWidth-1:0] fill_addr;

  assign flush_set = flush_cnt_q[SetWidth-1:0] & SetMask;

  if (Associativity > 1) begin : g_way_addr
    assign rd_addr   = {set_q, hit_way};
    assign fill_addr = {set_q, vict_way};
  end else begin : g_set_addr
    assign rd_addr   = set_q;
    assign fill_addr = set_q;
  end

  cache_victim_sel #(
    .NumSets      (NumSets),
    .Associativity(Associativity)
  ) u_victim_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == FLUSH),
    .adv_i    (fill),
    .adv_set_i(set_q),
    .rd_set_i (set_q),
    .rd_way_o (vict_way)
  );

  // Later ways overwrite earlier ones, so the highest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < Associativity; w++) begin
      if (info_q[set_q][w].valid && (info_q[set_q][w].tag == tag_q)) begin
        hit     = 1'b1;
        hit_way = WayWidth'(w);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    resp_valid_o    = 1'b0;
    flush_busy_o    = 1'b0;
    accept          = 1'b0;
    fill            = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i;
        if (flush_i) begin
          state_d = FLUSH;
        end else if (req_valid_i) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP:    state_d = hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid_i) begin
          fill    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        if (flush_cnt_q == LastSet) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      set_q       <= '0;
      tag_q       <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      flush_cnt_q <= '0;
      for (int unsigned s = 0; s < NumSets; s++) begin
        for (int unsigned w = 0; w < Associativity; w++) begin
          info_q[s][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_q <= req_set_i & SetMask;
        tag_q <= req_tag_i;
      end
      if (state_q == IDLE && flush_i) begin
        flush_cnt_q <= '0;
      end
      if (state_q == FLUSH) begin
        flush_cnt_q <= flush_cnt_q + CntWidth'(1);
        for (int unsigned w = 0; w < Associativity; w++) begin
          info_q[flush_set][w].valid <= 1'b0;
        end
      end
      if (state_q == LOOKUP && hit) begin
        resp_hit_q  <= 1'b1;
        resp_data_q <= data_q[rd_addr];
      end
      if (fill) begin
        info_q[set_q][vict_way] <= '{valid: 1'b1, tag: tag_q};
        resp_hit_q              <= 1'b0;
        resp_data_q             <= mem_resp_data_i;
      end
    end
  end

  // Data array is deliberately unreset; a fill coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (fill && rst_ni) begin
      data_q[fill_addr] <= mem_resp_data_i;
    end
  end

  assign resp_hit_o    = resp_hit_q;
  assign resp_data_o   = resp_data_q;
  assign mem_req_set_o = set_q;
  assign mem_req_tag_o = tag_q;

endmodule

// File: tb/tb_cache_refill.sv
// Directed self-checking bench for cache_refill (16 sets, 2 ways, 8-bit tag,
// 32-bit data): table of lookups plus hand-written backpressure/flush/reset cases.
module tb_cache_refill;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_set;
  logic [7:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [31:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [3:0]  mem_req_set;
  logic [7:0]  mem_req_tag;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush;
  logic        flush_busy;

  int checks;
  int failures;

  cache_refill #(
    .NumSets      (16),
    .Associativity(2),
    .TagWidth     (8),
    .DataWidth    (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_set_i       (req_set),
    .req_tag_i       (req_tag),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_hit_o      (resp_hit),
    .resp_data_o     (resp_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_set_o   (mem_req_set),
    .mem_req_tag_o   (mem_req_tag),
    .mem_resp_valid_i(mem_resp_valid),
    .mem_resp_data_i (mem_resp_data),
    .flush_i         (flush),
    .flush_busy_o    (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  set;
    logic [7:0]  tag;
    logic [31:0] mdata;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete lookup; called #1 after a clock edge with the DUT in IDLE.
  task automatic xact(input string nm, input logic [3:0] set, input logic [7:0] tag,
                      input logic [31:0] mdata, input logic exp_hit,
                      input logic [31:0] exp_data);
    check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_set   = set;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    tick();
    if (exp_hit) begin
      check({nm, "_no_memreq"}, 32'(mem_req_valid), 32'd0);
    end else begin
      check({nm, "_memreq_valid"}, 32'(mem_req_valid), 32'd1);
      check({nm, "_memreq_set"}, 32'(mem_req_set), 32'(set));
      check({nm, "_memreq_tag"}, 32'(mem_req_tag), 32'(tag));
      check({nm, "_no_early_resp"}, 32'(resp_valid), 32'd0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = mdata;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    check({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({nm, "_resp_hit"}, 32'(resp_hit), 32'(exp_hit));
    check({nm, "_resp_data"}, resp_data, exp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({nm, "_resp_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int busy_cycles;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_set        = '0;
    req_tag        = '0;
    resp_ready     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    flush          = 1'b0;

    vecs[0] = '{4'd3, 8'hA1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{4'd3, 8'hA1, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2] = '{4'd5, 8'h01, 32'h11111111, 1'b0, 32'h11111111};
    vecs[3] = '{4'd5, 8'h02, 32'h22222222, 1'b0, 32'h22222222};
    vecs[4] = '{4'd5, 8'h03, 32'h33333333, 1'b0, 32'h33333333};
    vecs[5] = '{4'd5, 8'h02, 32'h0,        1'b1, 32'h22222222};
    vecs[6] = '{4'd5, 8'h01, 32'h44444444, 1'b0, 32'h44444444};
    vecs[7] = '{4'd5, 8'h03, 32'h0,        1'b1, 32'h33333333};
    vecs[8] = '{4'd5, 8'h01, 32'h0,        1'b1, 32'h44444444};
    vecs[9] = '{4'd3, 8'hA2, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A};

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_flush_busy", 32'(flush_busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      xact($sformatf("vec%0d", i), vecs[i].set, vecs[i].tag, vecs[i].mdata,
           vecs[i].hit, vecs[i].data);
    end

    // Memory request backpressure, then response backpressure.
    req_valid = 1'b1;
    req_set   = 4'd7;
    req_tag   = 8'h55;
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_memreq_valid%0d", c), 32'(mem_req_valid), 32'd1);
      check($sformatf("bp_memreq_set%0d", c), 32'(mem_req_set), 32'd7);
      check($sformatf("bp_memreq_tag%0d", c), 32'(mem_req_tag), 32'h55);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    check("bp_memreq_dropped", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFEF00D;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_resp_valid%0d", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp_resp_hit%0d", c), 32'(resp_hit), 32'd0);
      check($sformatf("bp_resp_data%0d", c), resp_data, 32'hCAFEF00D);
      check($sformatf("bp_req_ready%0d", c), 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_resp_done", 32'(resp_valid), 32'd0);
    xact("bp_rehit", 4'd7, 8'h55, 32'h0, 1'b1, 32'hCAFEF00D);

    // Flush with a simultaneous request: flush wins.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_set   = 4'd9;
    req_tag   = 8'h77;
    #1;
    check("flush_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    busy_cycles = 0;
    while (flush_busy === 1'b1 && busy_cycles < 40) begin
      if (busy_cycles == 5) check("flush_req_ready_busy", 32'(req_ready), 32'd0);
      busy_cycles++;
      tick();
    end
    check("flush_busy_cycles", 32'(busy_cycles), 32'd16);
    check("flush_no_memreq", 32'(mem_req_valid), 32'd0);
    check("flush_no_resp", 32'(resp_valid), 32'd0);
    xact("flush_miss_a1", 4'd3, 8'hA1, 32'h0BADF00D, 1'b0, 32'h0BADF00D);
    xact("flush_miss_55", 4'd7, 8'h55, 32'h01020304, 1'b0, 32'h01020304);
    xact("flush_hit_a1", 4'd3, 8'hA1, 32'h0, 1'b1, 32'h0BADF00D);

    // Reset while waiting for refill data; the late data must be dropped.
    req_valid = 1'b1;
    req_set   = 4'd11;
    req_tag   = 8'h3C;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmiss_memreq", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h12345678;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rstmiss_no_resp%0d", c), 32'(resp_valid), 32'd0);
      tick();
    end
    check("rstmiss_idle", 32'(req_ready), 32'd1);
    xact("rstmiss_relookup", 4'd11, 8'h3C, 32'h87654321, 1'b0, 32'h87654321);
    xact("rstmiss_a1_cleared", 4'd3, 8'hA1, 32'hFEEDFACE, 1'b0, 32'hFEEDFACE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
